if_fetch_unit: RTL

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit_if.sv | 28 ++
 rtl/if_fetch_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port shared by the fetch unit and the memory.
//   imem_req   : read request, held until imem_ack
//   imem_addr  : word address, stable while imem_req=1
//   imem_ack   : one-cycle completion pulse, may coincide with the request cycle
//   imem_rdata : instruction word, valid with imem_ack
interface if_fetch_unit_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues one-at-a-time reads to instruction memory,
// buffers returned words in a 2-entry FIFO and feeds the IF/ID register.
//   clk, rst        : clock, asynchronous active-high reset
//   stall           : decode hazard stall, IF/ID holds
//   redirect        : taken branch/jump, drops buffered and in-flight words
//   redirect_target : new fetch address on redirect
//   imem            : instruction-memory master port
//   instruction     : FIFO-head word
//   pc_plus4        : FIFO-head fetch address + 4
//   ifid_write      : IF/ID load enable (also pops the FIFO head)
//   ifid_flush      : IF/ID bubble request
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [31:0]           redirect_target,
    if_fetch_unit_if.master       imem,
    output logic [31:0]           instruction,
    output logic [31:0]           pc_plus4,
    output logic                  ifid_write,
    output logic                  ifid_flush
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     count_after_pop;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic [XLEN-1:0]   fetch_pc_inc;

    // FIFO stores the already-incremented address so the head feeds pc_plus4
    // directly and reads as 0 after reset.
    logic [XLEN-1:0]   fifo_word_q [DEPTH];
    logic [XLEN-1:0]   fifo_word_d [DEPTH];
    logic [XLEN-1:0]   fifo_pc4_q  [DEPTH];
    logic [XLEN-1:0]   fifo_pc4_d  [DEPTH];

    logic              req_c;
    logic [XLEN-1:0]   addr_c;
    logic              push_c;
    logic              pop_c;

    assign fetch_pc_inc = fetch_pc_q + XLEN'(4);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_c && !imem.imem_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.imem_ack) begin
                    state_d = ST_IDLE;
                end else if (redirect) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem.imem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: memory request, FIFO push, IF/ID controls
    always_comb begin
        req_c      = 1'b0;
        addr_c     = fetch_pc_q;
        push_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Occupancy is the pre-pop count, so a full FIFO never
                // receives a push even if it is being drained this cycle.
                req_c  = (count_q < CW'(DEPTH)) && !redirect;
                addr_c = fetch_pc_q;
                push_c = req_c && imem.imem_ack;
            end
            ST_WAIT: begin
                req_c  = 1'b1;
                addr_c = req_addr_q;
                push_c = imem.imem_ack && !redirect;
            end
            ST_DROP: begin
                // Keep the stale request alive until memory completes it.
                req_c  = 1'b1;
                addr_c = req_addr_q;
            end
            default: ;
        endcase
        if (rst) begin
            req_c  = 1'b0;
            push_c = 1'b0;
        end
        pop_c      = !rst && (count_q != '0) && !stall && !redirect;
        ifid_write = pop_c;
        ifid_flush = rst || redirect || ((count_q == '0) && !stall);
    end

    assign imem.imem_req  = req_c;
    assign imem.imem_addr = addr_c;

    // Datapath next values: FIFO, count, fetch_pc, outstanding address
    always_comb begin
        fifo_word_d     = fifo_word_q;
        fifo_pc4_d      = fifo_pc4_q;
        count_d         = count_q;
        fetch_pc_d      = fetch_pc_q;
        req_addr_d      = req_addr_q;
        count_after_pop = count_q - CW'(pop_c);

        if (state_q == ST_IDLE && req_c && !imem.imem_ack) begin
            req_addr_d = fetch_pc_q;
        end

        if (redirect) begin
            count_d    = '0;
            fetch_pc_d = redirect_target;
        end else begin
            if (pop_c) begin
                fifo_word_d[0] = fifo_word_q[1];
                fifo_pc4_d[0]  = fifo_pc4_q[1];
            end
            if (push_c) begin
                fifo_word_d[count_after_pop[0]] = imem.imem_rdata;
                fifo_pc4_d[count_after_pop[0]]  = fetch_pc_inc;
                fetch_pc_d                      = fetch_pc_inc;
            end
            count_d = count_after_pop + CW'(push_c);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_word_q[i] <= '0;
                fifo_pc4_q[i]  <= '0;
            end
        end else begin
            count_q     <= count_d;
            fetch_pc_q  <= fetch_pc_d;
            req_addr_q  <= req_addr_d;
            fifo_word_q <= fifo_word_d;
            fifo_pc4_q  <= fifo_pc4_d;
        end
    end

    assign instruction = fifo_word_q[0];
    assign pc_plus4    = fifo_pc4_q[0];

endmodule
